// File: rtl/comparador_serie_ctrl.sv
// Word-serial magnitude compare of two WORDS*N-bit operands through one N-bit comparator.
// Optional build macro COMPARADOR_EARLY_EXIT_EN stops the scan at the first unequal word.

module comparador_nbits #(
    parameter int N = 2
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         gt_o,
    output logic         lt_o,
    output logic         eq_o
);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
endmodule

// state   | meaning
// IDLE    | waiting for start_in; operands captured on acceptance
// COMPARE | one word per cycle, most-significant word first
// DONE    | one-cycle done_out; results were loaded on entry
module comparador_serie_ctrl #(
    parameter int N     = 2,
    parameter int WORDS = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_in,
    input  logic [WORDS*N-1:0]         a_in,
    input  logic [WORDS*N-1:0]         b_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic                       gt_out,
    output logic                       lt_out,
    output logic                       eq_out,
    output logic [$clog2(WORDS+1)-1:0] words_out
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORDS - 1);

`ifdef COMPARADOR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORDS*N-1:0]   a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mism_q, mism_d;
    logic                 rgt_q, rgt_d, rlt_q, rlt_d;
    logic                 gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic [CNT_W-1:0]     words_q, words_d;

    logic [N-1:0] word_a, word_b;
    logic         cmp_gt, cmp_lt, cmp_eq;

    assign word_a = a_q[idx_q*N +: N];
    assign word_b = b_q[idx_q*N +: N];

    comparador_nbits #(.N(N)) u_cmp (
        .a_i  (word_a),
        .b_i  (word_b),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mism_d  = mism_q;
        rgt_d   = rgt_q;
        rlt_d   = rlt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        words_d = words_q;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = IDX_TOP;
                    cnt_d   = '0;
                    mism_d  = 1'b0;
                    rgt_d   = 1'b0;
                    rlt_d   = 1'b0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // only the most-significant differing word decides the result
                if (!cmp_eq && !mism_q) begin
                    mism_d = 1'b1;
                    rgt_d  = cmp_gt;
                    rlt_d  = cmp_lt;
                end
                if ((idx_q == '0) || (EARLY && mism_d)) begin
                    state_d = S_DONE;
                    gt_d    = rgt_d;
                    lt_d    = rlt_d;
                    eq_d    = !mism_d;
                    words_d = cnt_d;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            rgt_q   <= 1'b0;
            rlt_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
            rgt_q   <= rgt_d;
            rlt_q   <= rlt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            words_q <= words_d;
        end
    end

    assign busy_out  = (state_q == S_COMPARE);
    assign done_out  = (state_q == S_DONE);
    assign gt_out    = gt_q;
    assign lt_out    = lt_q;
    assign eq_out    = eq_q;
    assign words_out = words_q;

endmodule

// File: tb/tb_comparador_serie_ctrl.sv
// Scoreboard bench for comparador_serie_ctrl (N=2, WORDS=4); follows COMPARADOR_EARLY_EXIT_EN if defined.

module tb_comparador_serie_ctrl;
    localparam int N     = 2;
    localparam int WORDS = 4;
    localparam int W     = WORDS * N;
    localparam int CW    = $clog2(WORDS + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b;
    logic          busy_out, done_out, gt_out, lt_out, eq_out;
    logic [CW-1:0] words_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic          gt;
        logic          lt;
        logic          eq;
        logic [CW-1:0] words;
        int            accept;
    } exp_t;

    exp_t sb[$];

    comparador_serie_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .start_in  (start),
        .a_in      (a),
        .b_in      (b),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .gt_out    (gt_out),
        .lt_out    (lt_out),
        .eq_out    (eq_out),
        .words_out (words_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer magnitude compare; word count from the top down.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input int acc);
        exp_t e;
        bit   found;
        e.gt     = (av > bv);
        e.lt     = (av < bv);
        e.eq     = (av == bv);
        e.words  = CW'(WORDS);
        e.accept = acc;
        found    = 1'b0;
`ifdef COMPARADOR_EARLY_EXIT_EN
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (!found && (av[i*N +: N] != bv[i*N +: N])) begin
                e.words = CW'(WORDS - i);
                found   = 1'b1;
            end
        end
`endif
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done_out) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_out=1 at cycle %0d, required no pending request", cyc);
            end else begin
                e = sb.pop_front();
                checks += 5;
                if (gt_out !== e.gt) begin
                    errors++;
                    $display("FAIL done_gt: got %0b required %0b", gt_out, e.gt);
                end
                if (lt_out !== e.lt) begin
                    errors++;
                    $display("FAIL done_lt: got %0b required %0b", lt_out, e.lt);
                end
                if (eq_out !== e.eq) begin
                    errors++;
                    $display("FAIL done_eq: got %0b required %0b", eq_out, e.eq);
                end
                if (words_out !== e.words) begin
                    errors++;
                    $display("FAIL done_words: got %0d required %0d", words_out, e.words);
                end
                if ((cyc - e.accept) != int'(e.words)) begin
                    errors++;
                    $display("FAIL done_latency: got %0d required %0d", cyc - e.accept, e.words);
                end
            end
        end
    end

    task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        sb.push_back(model(av, bv, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !busy_out && !done_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy_out); end
        if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", done_out); end
        if (gt_out !== 1'b0)   begin errors++; $display("FAIL reset_gt: got %0b required 0", gt_out); end
        if (lt_out !== 1'b0)   begin errors++; $display("FAIL reset_lt: got %0b required 0", lt_out); end
        if (eq_out !== 1'b0)   begin errors++; $display("FAIL reset_eq: got %0b required 0", eq_out); end
        if (words_out !== '0)  begin errors++; $display("FAIL reset_words: got %0d required 0", words_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_equal();
        bit ok;
        pulse_start(8'hA5, 8'hA5);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL equal_timeout: got busy=%0b pending=%0d required idle", busy_out, sb.size()); end
        repeat (3) @(negedge clk);
        checks += 2;
        if (eq_out !== 1'b1)   begin errors++; $display("FAIL equal_hold_eq: got %0b required 1", eq_out); end
        if (done_out !== 1'b0) begin errors++; $display("FAIL equal_hold_done: got %0b required 0", done_out); end
    endtask

    task automatic test_gt();
        bit ok;
        pulse_start(8'hC0, 8'h40);
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL gt_busy: got %0b required 1", busy_out); end
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL gt_timeout: got busy=%0b pending=%0d required idle", busy_out, sb.size()); end
        if (gt_out !== 1'b1) begin errors++; $display("FAIL gt_hold: got %0b required 1", gt_out); end
    endtask

    task automatic test_lt();
        bit ok;
        pulse_start(8'h1E, 8'h1F);
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL lt_timeout: got busy=%0b pending=%0d required idle", busy_out, sb.size()); end
        if (lt_out !== 1'b1) begin errors++; $display("FAIL lt_hold: got %0b required 1", lt_out); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        @(negedge clk);
        a     = 8'h80;
        b     = 8'h10;
        start = 1'b1;
        sb.push_back(model(8'h80, 8'h10, cyc + 1));
        @(negedge clk);
        a = 8'h00;
        b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle(ok);
        repeat (8) @(negedge clk);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL ignore_timeout: got busy=%0b pending=%0d required idle", busy_out, sb.size()); end
        if (gt_out !== 1'b1) begin errors++; $display("FAIL ignore_gt: got %0b required 1", gt_out); end
        if (busy_out !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %0b required 0", busy_out); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        sb.push_back(model(8'h01, 8'h02, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checks += 6;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b required 0", busy_out); end
        if (done_out !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b required 0", done_out); end
        if (gt_out !== 1'b0)   begin errors++; $display("FAIL abort_gt: got %0b required 0", gt_out); end
        if (lt_out !== 1'b0)   begin errors++; $display("FAIL abort_lt: got %0b required 0", lt_out); end
        if (eq_out !== 1'b0)   begin errors++; $display("FAIL abort_eq: got %0b required 0", eq_out); end
        if (words_out !== '0)  begin errors++; $display("FAIL abort_words: got %0d required 0", words_out); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        pulse_start(8'h03, 8'h03);
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL abort_restart_timeout: got busy=%0b pending=%0d required idle", busy_out, sb.size()); end
        if (eq_out !== 1'b1) begin errors++; $display("FAIL abort_restart_eq: got %0b required 1", eq_out); end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        bit   seen;
        int   base;
        int   period;
        exp_t e;
        e      = model(8'hFF, 8'h00, 0);
        period = int'(e.words) + 2;
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        base  = cyc + 1;
        for (int k = 0; base + k * period <= base + 19; k++)
            sb.push_back(model(8'hFF, 8'h00, base + k * period));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_out) seen = 1'b1;
            if (seen) begin
                checks++;
                if (gt_out !== 1'b1) begin errors++; $display("FAIL b2b_gt: got %0b required 1 at cycle %0d", gt_out, cyc); end
            end
        end
        start = 1'b0;
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy=%0b pending=%0d required idle", busy_out, sb.size()); end
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_gt();
        test_lt();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comparador_serie_ctrl.md
# comparador_serie_ctrl

Sequencing controller that compares two wide operands of `WORDS*N` bits using a single `N`-bit magnitude comparator. It walks the operand words from most-significant to least-significant, one word per clock, and locks in the first inequality. It sits between a requester, which supplies operands through a start/done handshake, and the `comparador_nbits` datapath it instantiates internally. It delivers registered `gt`/`lt`/`eq` results plus the number of words examined.

## Interface
- `N`, default 2: width of one word; the width of the internal comparator.
- `WORDS`, default 4: number of words per operand; must be ≥ 1.
- `clk_in`  input  1  clock; all state changes on rising edge.
- `rst_n_in`  input  1  synchronous, active-low reset.
- `start_in`  input  1  request a comparison; sampled only in IDLE.
- `a_in`  input  WORDS*N  operand A; word i is `a_in[i*N +: N]`; word WORDS-1 is most significant.
- `b_in`  input  WORDS*N  operand B; same layout as `a_in`.
- `busy_out`  output  1  high while in COMPARE.
- `done_out`  output  1  one-cycle pulse when results update.
- `gt_out`  output  1  A > B (registered).
- `lt_out`  output  1  A < B (registered).
- `eq_out`  output  1  A == B (registered).
- `words_out`  output  $clog2(WORDS+1)  number of words compared in the last operation.

## Operation
- States:
  - IDLE: `busy_out`=0, `done_out`=0. On `start_in`=1, capture `a_in`/`b_in` into internal registers, set index to WORDS-1, clear the internal mismatch flag and word count, then go to COMPARE.
  - COMPARE:
    - Each cycle, drive the comparator with captured word[index] and increment the count.
    - If the words differ and no mismatch is yet recorded, record `gt`/`lt` from the comparator and set the mismatch flag. Later words never overwrite a recorded result.
    - Go to DONE when index==0, or on the first mismatch if `EARLY_EXIT_EN` is defined. Otherwise decrement index.
  - DONE: `done_out`=1 for exactly one cycle. `gt_out`/`lt_out`/`eq_out`/`words_out` load on entry to DONE; `eq_out` = no mismatch recorded. Always return to IDLE.
- Output hold: `gt_out`, `lt_out`, `eq_out` and `words_out` hold their values until the next entry to DONE. Exactly one of gt/lt/eq is 1 after the first completed operation.
- Operands are captured only at start acceptance; changes on `a_in`/`b_in` during COMPARE have no effect.
- `start_in` is ignored in COMPARE and DONE. No queuing.
- Reset (`rst_n_in`=0 at an edge): state IDLE; all outputs 0, including `eq_out`; internal registers 0. Reset mid-COMPARE aborts with no `done_out` pulse.

## Timing
- Start accepted at edge E0; `busy_out` high from E0.
- The word compared at edge Ek is word WORDS-k.
- Full scan: `done_out` is high for the cycle after edge E_WORDS, i.e. WORDS cycles after acceptance.
- Early exit on the k-th word: `done_out` is high after edge Ek.
- `busy_out` falls at the same edge `done_out` rises. `done_out` falls at the next edge, when the state is back in IDLE.
- Minimum start-to-start spacing is (words compared + 2) cycles. A start held high continuously is re-accepted in the first IDLE cycle after DONE.

## Configuration
- `COMPARADOR_EARLY_EXIT_EN` defined: COMPARE ends at the first unequal word, and `words_out` equals the index of the first mismatch from the top (1..WORDS).
- Not defined: every operation scans all WORDS words, giving constant latency; `words_out` is always WORDS. Results are identical in both builds.

## Test plan
All scenarios use N=2, WORDS=4.
- a=8'hA5, b=8'hA5, start pulse -> `done_out` 4 cycles after acceptance; eq=1, gt=0, lt=0, `words_out`=4 (both builds).
- a=8'hC0, b=8'h40 -> gt=1 in both builds.
  - With macro: `done_out` 1 cycle after acceptance, `words_out`=1.
  - Without macro: 4 cycles, `words_out`=4.
- a=8'h1E, b=8'h1F -> lt=1 (mismatch in word 0); `done_out` after 4 cycles and `words_out`=4 in both builds.
- Start with a=8'h80, b=8'h10, then change to a=8'h00, b=8'hFF and pulse `start_in` during COMPARE -> result gt=1; the second start is ignored and there is only one `done_out` pulse.
- Start with a=8'h01, b=8'h02, then `rst_n_in`=0 one cycle after acceptance -> no `done_out`; all outputs 0. A following start with a=8'h03, b=8'h03 -> eq=1 after 4 cycles.
- `start_in` held high for 20 cycles with a=8'hFF, b=8'h00 -> repeated single-cycle `done_out` pulses. With the macro the period is 3 cycles; without it the period is 6. gt=1 throughout after the first done.
